alu_operand_arbiter: RTL and testbench

//  Round-robin arbiter that shares one ALU operand input between two requesters (A, B).

---
 rtl/alu_operand_arbiter_pkg.sv | 18 +
 rtl/mux_2_1.sv | 12 +
 rtl/alu_operand_arbiter.sv | 114 +++++++++++
 tb/tb_alu_operand_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_arbiter_pkg.sv
// Shared encodings for the ALU operand arbiter.
// State and mux-select values used by the FSM and the mux bank.
package alu_operand_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_A = 2'd1,
    ARB_GNT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic arb_state_t grant_of(input logic s);
    return (s == SEL_B) ? ARB_GNT_B : ARB_GNT_A;
  endfunction

endpackage

// File: rtl/mux_2_1.sv
// Single-bit 2:1 mux cell.
// select 0 -> A, select 1 -> B.
module mux_2_1 (
  output logic out,
  input  logic A,
  input  logic B,
  input  logic select
);

  assign out = select ? B : A;

endmodule

// File: rtl/alu_operand_arbiter.sv
// Round-robin arbiter sharing one ALU operand between requesters A and B.
// Define ALU_ARB_STATS_EN to add saturating per-requester accept counters.
module alu_operand_arbiter
  import alu_operand_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef ALU_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ALU_ARB_STATS_EN
  , output logic [CNT_W-1:0] cnt_a
  , output logic [CNT_W-1:0] cnt_b
`endif
);

  arb_state_t state;
  arb_state_t nxt;
  logic       sel;
  logic       last;
  logic       accept;

  assign out_valid = grant_a | grant_b;
  assign accept    = out_valid & out_ready;
  assign ack_a     = grant_a & out_ready;
  assign ack_b     = grant_b & out_ready;

  // On accept the other requester goes first; a held req is a new operand.
  always_comb begin
    nxt = state;
    unique case (state)
      ARB_IDLE: begin
        unique case (1'b1)
          req_a & req_b:  nxt = grant_of(~last);
          req_a & ~req_b: nxt = ARB_GNT_A;
          ~req_a & req_b: nxt = ARB_GNT_B;
          default:        nxt = ARB_IDLE;
        endcase
      end
      ARB_GNT_A: begin
        if (out_ready) begin
          nxt = req_b ? ARB_GNT_B : (req_a ? ARB_GNT_A : ARB_IDLE);
        end else if (!req_a) begin
          nxt = ARB_IDLE;
        end
      end
      ARB_GNT_B: begin
        if (out_ready) begin
          nxt = req_a ? ARB_GNT_A : (req_b ? ARB_GNT_B : ARB_IDLE);
        end else if (!req_b) begin
          nxt = ARB_IDLE;
        end
      end
      default: nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ARB_IDLE;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      sel     <= SEL_A;
      last    <= SEL_B;
    end else begin
      state   <= nxt;
      grant_a <= (nxt == ARB_GNT_A);
      grant_b <= (nxt == ARB_GNT_B);
      sel     <= (nxt == ARB_GNT_B) ? SEL_B : SEL_A;
      if (accept) begin
        last <= sel;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_2_1 u_mux (
      .out    (data_out[i]),
      .A      (data_a[i]),
      .B      (data_b[i]),
      .select (sel)
    );
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (ack_a && (cnt_a != '1)) begin
        cnt_a <= cnt_a + 1'b1;
      end
      if (ack_b && (cnt_b != '1)) begin
        cnt_b <= cnt_b + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Scoreboard bench for alu_operand_arbiter: directed cases plus random traffic.
// A transaction-level model predicts each accepted transfer; a monitor checks them.
module tb_alu_operand_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b, out_ready;
  logic [7:0] data_a, data_b, data_out;
  logic       grant_a, grant_b, ack_a, ack_b, out_valid;
`ifdef ALU_ARB_STATS_EN
  localparam int CW = 4;
  logic [CW-1:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  alu_operand_arbiter #(
    .WIDTH(8)
`ifdef ALU_ARB_STATS_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .ack_a     (ack_a),
    .ack_b     (ack_b),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ALU_ARB_STATS_EN
    , .cnt_a   (cnt_a)
    , .cnt_b   (cnt_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         src;
    logic [7:0] d;
  } xfer_t;
  xfer_t q[$];
  xfer_t e_m;

  // Model: owner 0=none, 1=A, 2=B; last = most recently served owner.
  int m_own;
  int m_last;
  bit m_acc_a, m_acc_b;
  int n_acc_a;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_own   = 0;
    m_last  = 2;
    m_acc_a = 1'b0;
    m_acc_b = 1'b0;
  endfunction

  function automatic void m_next();
    bit r[3];
    r[0] = 1'b0;
    r[1] = req_a;
    r[2] = req_b;
    if (reset) begin
      m_reset();
      return;
    end
    if (m_own == 0) begin
      if (r[1] && r[2]) m_own = 3 - m_last;
      else if (r[1]) m_own = 1;
      else if (r[2]) m_own = 2;
    end else if (out_ready) begin
      m_last = m_own;
      if (r[3 - m_own]) m_own = 3 - m_own;
      else if (!r[m_own]) m_own = 0;
    end else if (!r[m_own]) begin
      m_own = 0;
    end
  endfunction

  task automatic m_eval();
    m_acc_a = (m_own == 1) && out_ready;
    m_acc_b = (m_own == 2) && out_ready;
    if (m_acc_a) begin
      q.push_back('{1'b0, data_a});
      n_acc_a++;
    end
    if (m_acc_b) q.push_back('{1'b1, data_b});
  endtask

  // out_ready may change after edge(); req/data may change after settle().
  task automatic edge_();
    @(posedge clk);
    m_next();
    #1;
  endtask

  task automatic settle();
    m_eval();
    @(negedge clk);
    #1;
  endtask

  task automatic cyc();
    edge_();
    settle();
  endtask

  task automatic do_reset();
    req_a     = 1'b0;
    req_b     = 1'b0;
    out_ready = 1'b0;
    data_a    = 8'h00;
    data_b    = 8'h00;
    reset     = 1'b1;
    m_reset();
    q.delete();
    n_acc_a = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if ((ack_a | ack_b) && !out_valid) begin
        n_tests++;
        n_fail++;
        $display("FAIL ack_no_valid: ack_a=%b ack_b=%b", ack_a, ack_b);
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_xfer: unexpected data %0h ack_a=%b ack_b=%b",
                   data_out, ack_a, ack_b);
        end else begin
          e_m = q.pop_front();
          if (data_out !== e_m.d || ack_a !== !e_m.src || ack_b !== e_m.src) begin
            n_fail++;
            $display("FAIL sb_xfer: got data %0h ack_a=%b ack_b=%b expected data %0h src_b=%b",
                     data_out, ack_a, ack_b, e_m.d, e_m.src);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    out_ready = 1'b0;
    data_a = 8'h00;
    data_b = 8'h00;
    m_reset();
    n_acc_a = 0;
    #3;
    chk("rst_grant_a", grant_a, 0);
    chk("rst_grant_b", grant_b, 0);
    chk("rst_valid", out_valid, 0);
    do_reset();

    // single request, consumed immediately
    req_a = 1'b1;
    data_a = 8'h5A;
    out_ready = 1'b1;
    cyc();
    chk("t1_grant_a", grant_a, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", data_out, 8'h5A);
    chk("t1_ack_a", ack_a, 1);
    req_a = 1'b0;
    cyc();
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_grant", grant_a, 0);

    // tie after reset alternates starting with A
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    data_a = 8'h11;
    data_b = 8'h22;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_alt", data_out, (i % 2) ? 8'h22 : 8'h11);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    cyc();
    chk("t2_idle", out_valid, 0);

    // backpressure holds GNT_B
    req_b = 1'b1;
    data_b = 8'h3C;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_grant_b", grant_b, 1);
      chk("t3_valid", out_valid, 1);
      chk("t3_data", data_out, 8'h3C);
      chk("t3_no_ack", ack_b, 0);
    end
    edge_();
    out_ready = 1'b1;
    settle();
    chk("t3_ack_b", ack_b, 1);
    req_b = 1'b0;
    cyc();
    chk("t3_single_ack", ack_b, 0);
    chk("t3_idle", out_valid, 0);

    // withdraw without accept
    edge_();
    out_ready = 1'b0;
    settle();
    req_a = 1'b1;
    data_a = 8'h77;
    cyc();
    chk("t4_grant_a", grant_a, 1);
    chk("t4_no_ack", ack_a, 0);
    req_a = 1'b0;
    cyc();
    chk("t4_valid", out_valid, 0);
    chk("t4_grant", grant_a, 0);
    chk("t4_ack", ack_a, 0);

    // asynchronous reset in the middle of GNT_B
    do_reset();
    req_b = 1'b1;
    data_b = 8'h22;
    cyc();
    chk("t5_grant_b", grant_b, 1);
    out_ready = 1'b1;
    #1;
    chk("t5_pre_ack", ack_b, 1);
    reset = 1'b1;
    m_reset();
    q.delete();
    #1;
    chk("t5_grant_b_rst", grant_b, 0);
    chk("t5_valid_rst", out_valid, 0);
    chk("t5_ack_rst", ack_b, 0);
    reset = 1'b0;
    req_a = 1'b1;
    data_a = 8'h11;
    cyc();
    chk("t5_tie_a", grant_a, 1);
    chk("t5_tie_data", data_out, 8'h11);
    req_a = 1'b0;
    req_b = 1'b0;
    cyc();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    req_a = 1'b1;
    data_a = 8'h42;
    out_ready = 1'b1;
    repeat (21) cyc();
    req_a = 1'b0;
    cyc();
    chk("t6_cnt_a", cnt_a, (n_acc_a > 15) ? 15 : n_acc_a);
    chk("t6_cnt_b", cnt_b, 0);
`endif

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      edge_();
      out_ready = ($urandom_range(0, 9) < 7);
      settle();
      if (req_a && m_acc_a) begin
        if ($urandom_range(0, 1) == 0) req_a = 1'b0;
        else data_a = 8'($urandom);
      end else if (req_a) begin
        if ($urandom_range(0, 19) == 0) req_a = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req_a = 1'b1;
        data_a = 8'($urandom);
      end
      if (req_b && m_acc_b) begin
        if ($urandom_range(0, 1) == 0) req_b = 1'b0;
        else data_b = 8'($urandom);
      end else if (req_b) begin
        if ($urandom_range(0, 19) == 0) req_b = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req_b = 1'b1;
        data_b = 8'($urandom);
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (3) cyc();
    chk("sb_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
